aes_core_stub_responder: RTL and testbench
==========================================

// Module: aes_core_stub_responder
// PURPOSE
//  Responder end of the controller<->AES-core handshake (EN/Din/Kin/KDrdy in; Dout/Dvld/Kvld/BSY/Trigger out).
//  Stands in for the DRAM CIM AES core during UART-controller bring-up, so the link works without the DRAM chip.
//  Returns Din XOR key after a fixed, programmable latency, with real key-load/busy timing and protocol-violation flagging.
// PARAMETERS
//  LATENCY      11  cycles from the EN-accept edge to the Dvld pulse; legal range 1..255
//  KEY_LATENCY  4   cycles from the KDrdy-accept edge to the Kvld pulse; legal range 1..255
// PORTS
//  CLK      in   1    system clock; single clock domain
//  RST      in   1    synchronous reset, active-high
//  RSTn     in   1    controller soft reset, synchronous, active-low; same effect as RST
//  EN       in   1    encrypt request, sampled on CLK rising edge
//  Din      in   128  plaintext, captured on EN accept
//  Kin      in   128  key, captured on KDrdy accept
//  KDrdy    in   1    key-load request, sampled on CLK rising edge
//  Dout     out  128  result; holds its value until the next Dvld
//  Dvld     out  1    one-cycle pulse: Dout valid
//  Kvld     out  1    one-cycle pulse: key loaded
//  BSY      out  1    high while a key load or encrypt is in progress
//  Trigger  out  1    scope trigger; high during encrypt only
//  ERR      out  1    sticky protocol-violation flag; cleared only by reset
// BEHAVIOUR
//  Reset (RST=1 or RSTn=0 at an edge):
//   - state=IDLE, cnt=0, key_reg=0, din_reg=0
//   - Dout=0, Dvld=0, Kvld=0, BSY=0, Trigger=0, ERR=0
//   - Takes precedence over every other input. An operation in flight is aborted and produces no pulse.
//  FSM states: IDLE (no key), KEYLOAD, READY (key valid), BUSY (encrypt).
//  Key load: KDrdy=1 in IDLE or READY at edge k:
//   - key_reg<=Kin; cnt<=KEY_LATENCY-1; BSY<=1; ->KEYLOAD
//   - At each edge in KEYLOAD: if cnt!=0, cnt--.
//   - Else: Kvld<=1 for one cycle, BSY<=0, ->READY. Kvld is therefore high in cycle k+KEY_LATENCY.
//  Encrypt: EN=1 in READY at edge k:
//   - din_reg<=Din; cnt<=LATENCY-1; BSY<=1; Trigger<=1; ->BUSY
//   - At each edge in BUSY: if cnt!=0, cnt--.
//   - Else: Dout<=din_reg^key_reg, Dvld<=1 for one cycle, BSY<=0, Trigger<=0, ->READY.
//   - Dvld is therefore high in cycle k+LATENCY.
//  Back-to-back: EN or KDrdy asserted in the cycle Dvld or Kvld is high is accepted (state is already READY).
//  Violations: the request is ignored and ERR<=1 in each of these cases:
//   - EN in IDLE (no key loaded)
//   - EN or KDrdy while in KEYLOAD or BUSY
//   - EN and KDrdy together in READY: KDrdy is accepted, EN is dropped, ERR<=1
//  A re-key in READY replaces key_reg. Kvld pulses again; Dout is unchanged.
//  cnt is 8 bits and never wraps: it decrements only when non-zero.
//  Din and Kin are sampled only at the accept edge. Later changes do not affect the result.
//  Dvld and Kvld are never high in the same cycle.
// TESTING
//  1 Reset, then KDrdy pulse with Kin=000102030405060708090a0b0c0d0e0f.
//    -> BSY high for 4 cycles; Kvld pulses 4 cycles after the KDrdy edge; ERR=0.
//  2 After test 1: EN with Din=00112233445566778899aabbccddeeff.
//    -> Dvld pulses 11 cycles later; Dout=00102030405060708090a0b0c0d0e0f0; Trigger high for exactly 11 cycles.
//  3 EN without any key loaded.
//    -> no Dvld, BSY stays 0, ERR=1 and stays 1 until RST.
//  4 EN repeated at cycle 5 of an encrypt.
//    -> the original Dvld still occurs at cycle 11 with the first result; ERR=1.
//    Then EN in the Dvld cycle -> a second Dvld 11 cycles later.
//  5 RST=1 for one cycle at cycle 6 of an encrypt.
//    -> all outputs 0 next cycle; no Dvld ever appears; state IDLE (a following EN sets ERR).
//  6 EN+KDrdy in the same cycle in READY with Kin=ff..ff.
//    -> Kvld after 4 cycles; no Dvld; ERR=1.
//    A following EN with Din=0 -> Dout=ff..ff.

Source files
------------

// File: rtl/aes_core_stub_responder.sv
// Stand-in for the DRAM CIM AES core: answers the controller handshake with Din ^ key
// after fixed, parameterised key-load and encrypt latencies, and flags protocol misuse.
//
// state   | meaning
// IDLE    | no key loaded; only KDrdy is accepted
// KEYLOAD | key captured, counting down to the Kvld pulse
// READY   | key valid; EN or KDrdy accepted
// BUSY    | encrypt in progress, counting down to the Dvld pulse
module aes_core_stub_responder #(
  parameter int unsigned LATENCY     = 11,  // 1..255
  parameter int unsigned KEY_LATENCY = 4    // 1..255
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         RSTn,
  input  logic         EN,
  input  logic [127:0] Din,
  input  logic [127:0] Kin,
  input  logic         KDrdy,
  output logic [127:0] Dout,
  output logic         Dvld,
  output logic         Kvld,
  output logic         BSY,
  output logic         Trigger,
  output logic         ERR
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    KEYLOAD = 2'd1,
    READY   = 2'd2,
    BUSY    = 2'd3
  } state_t;

  // The counter is loaded with latency-1 so the pulse lands exactly LATENCY edges after accept.
  localparam logic [7:0] ENC_LOAD = 8'(LATENCY - 1);
  localparam logic [7:0] KEY_LOAD = 8'(KEY_LATENCY - 1);

  state_t       state, state_nxt;
  logic [7:0]   cnt, cnt_nxt;
  logic [127:0] key_reg, key_nxt;
  logic [127:0] din_reg, din_nxt;
  logic [127:0] dout_nxt;
  logic         dvld_nxt, kvld_nxt, bsy_nxt, trig_nxt, err_nxt;
  logic         rst_any;

  assign rst_any = RST | ~RSTn;

  always_ff @(posedge CLK) begin
    if (rst_any) begin
      state   <= IDLE;
      cnt     <= '0;
      key_reg <= '0;
      din_reg <= '0;
      Dout    <= '0;
      Dvld    <= 1'b0;
      Kvld    <= 1'b0;
      BSY     <= 1'b0;
      Trigger <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      key_reg <= key_nxt;
      din_reg <= din_nxt;
      Dout    <= dout_nxt;
      Dvld    <= dvld_nxt;
      Kvld    <= kvld_nxt;
      BSY     <= bsy_nxt;
      Trigger <= trig_nxt;
      ERR     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    key_nxt   = key_reg;
    din_nxt   = din_reg;
    dout_nxt  = Dout;
    dvld_nxt  = 1'b0;
    kvld_nxt  = 1'b0;
    bsy_nxt   = BSY;
    trig_nxt  = Trigger;
    err_nxt   = ERR;

    case (state)
      IDLE: begin
        if (KDrdy) begin
          key_nxt   = Kin;
          cnt_nxt   = KEY_LOAD;
          bsy_nxt   = 1'b1;
          state_nxt = KEYLOAD;
        end
        // Encrypt without a key is always a violation, even alongside a key load.
        if (EN) err_nxt = 1'b1;
      end

      READY: begin
        if (KDrdy) begin
          key_nxt   = Kin;
          cnt_nxt   = KEY_LOAD;
          bsy_nxt   = 1'b1;
          state_nxt = KEYLOAD;
          if (EN) err_nxt = 1'b1;
        end else if (EN) begin
          din_nxt   = Din;
          cnt_nxt   = ENC_LOAD;
          bsy_nxt   = 1'b1;
          trig_nxt  = 1'b1;
          state_nxt = BUSY;
        end
      end

      KEYLOAD: begin
        if (EN || KDrdy) err_nxt = 1'b1;
        if (cnt != 8'd0) begin
          cnt_nxt = cnt - 8'd1;
        end else begin
          kvld_nxt  = 1'b1;
          bsy_nxt   = 1'b0;
          state_nxt = READY;
        end
      end

      BUSY: begin
        if (EN || KDrdy) err_nxt = 1'b1;
        if (cnt != 8'd0) begin
          cnt_nxt = cnt - 8'd1;
        end else begin
          dout_nxt  = din_reg ^ key_reg;
          dvld_nxt  = 1'b1;
          bsy_nxt   = 1'b0;
          trig_nxt  = 1'b0;
          state_nxt = READY;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_core_stub_responder.sv
// Scoreboard bench for aes_core_stub_responder: stimulus pushes expected Kvld/Dvld events
// (cycle and data); a negedge monitor pops and compares whenever a pulse appears.
module tb_aes_core_stub_responder;

  localparam int LAT  = 11;
  localparam int KLAT = 4;

  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] D1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] R11  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] D2   = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] R21  = 128'hffefdfcfbfaf9f8f7f6f5f4f3f2f1f0f;
  localparam logic [127:0] ONES = {128{1'b1}};

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         RSTn = 1'b1;
  logic         EN = 1'b0;
  logic         KDrdy = 1'b0;
  logic [127:0] Din = '0;
  logic [127:0] Kin = '0;
  logic [127:0] Dout;
  logic         Dvld, Kvld, BSY, Trigger, ERR;

  aes_core_stub_responder #(.LATENCY(LAT), .KEY_LATENCY(KLAT)) dut (
    .CLK(CLK), .RST(RST), .RSTn(RSTn), .EN(EN), .Din(Din), .Kin(Kin), .KDrdy(KDrdy),
    .Dout(Dout), .Dvld(Dvld), .Kvld(Kvld), .BSY(BSY), .Trigger(Trigger), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit           is_key;
    int           at;
    logic [127:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   bsy_n, trig_n;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every Dvld/Kvld pulse must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (Dvld && Kvld) chk("dvld_kvld_overlap", 1'b1, 1'b0);
    else if (Dvld || Kvld) begin
      if (exp_q.size() == 0) begin
        chk(Dvld ? "unexpected_dvld" : "unexpected_kvld", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_kind_is_key", Kvld, e.is_key);
        chk("pulse_cycle", 128'(cyc), 128'(e.at));
        if (Dvld) chk("dout", Dout, e.data);
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
    if (BSY) bsy_n++;
    if (Trigger) trig_n++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Request sampled on the next rising edge; Din/Kin are scrambled afterwards.
  task automatic req(input logic en, input logic kd, input logic [127:0] d, input logic [127:0] k);
    EN = en; KDrdy = kd; Din = d; Kin = k;
    tick();
    EN = 0; KDrdy = 0; Din = 128'h5a5a_a5a5_dead_beef_0123_4567_89ab_cdef; Kin = ~Kin;
  endtask

  task automatic push(input bit is_key, input int lat, input logic [127:0] d);
    exp_t e;
    e.is_key = is_key; e.at = cyc + 1 + lat; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin tick(); n++; end
    chk("drain_timeout", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic do_reset();
    RST = 1; tick(); RST = 0;
  endtask

  task automatic load_key(input logic [127:0] k);
    push(1'b1, KLAT, '0);
    req(1'b0, 1'b1, '0, k);
    drain(20);
  endtask

  initial begin
    int t_exp;
    // Reset state
    ticks(2);
    chk("rst_dout", Dout, '0);
    chk("rst_pulses", {Dvld, Kvld}, 2'b00);
    chk("rst_bsy_trig_err", {BSY, Trigger, ERR}, 3'b000);
    RST = 0;
    tick();

    // 1: key load, BSY for 4 cycles
    bsy_n = 0;
    push(1'b1, KLAT, '0);
    req(1'b0, 1'b1, '0, K1);
    ticks(7);
    chk("t1_bsy_cycles", 128'(bsy_n), 128'd4);
    chk("t1_err", ERR, 1'b0);
    drain(5);

    // 2: encrypt, Trigger high exactly 11 cycles
    trig_n = 0; bsy_n = 0;
    push(1'b0, LAT, R11);
    req(1'b1, 1'b0, D1, '0);
    ticks(14);
    chk("t2_trig_cycles", 128'(trig_n), 128'd11);
    chk("t2_bsy_cycles", 128'(bsy_n), 128'd11);
    chk("t2_err", ERR, 1'b0);
    drain(5);

    // 3: EN with no key
    do_reset();
    bsy_n = 0;
    req(1'b1, 1'b0, D1, '0);
    ticks(15);
    chk("t3_bsy_cycles", 128'(bsy_n), 128'd0);
    chk("t3_err_set", ERR, 1'b1);
    ticks(5);
    chk("t3_err_sticky", ERR, 1'b1);
    RSTn = 0; tick(); RSTn = 1;
    chk("t3_rstn_clears_err", ERR, 1'b0);

    // 4: EN during encrypt is ignored; EN in the Dvld cycle is accepted
    load_key(K1);
    push(1'b0, LAT, R11);
    t_exp = cyc + 1 + LAT;
    req(1'b1, 1'b0, D1, '0);
    ticks(3);
    req(1'b1, 1'b0, D2, '0);
    chk("t4_err", ERR, 1'b1);
    for (int i = 0; i < 30 && cyc < t_exp; i++) tick();
    chk("t4_dvld_at_expected", Dvld, 1'b1);
    push(1'b0, LAT, R21);
    req(1'b1, 1'b0, D2, '0);
    drain(20);

    // 5: reset mid-encrypt aborts it
    do_reset();
    load_key(K1);
    req(1'b1, 1'b0, D1, '0);
    ticks(4);
    do_reset();
    chk("t5_dout_cleared", Dout, '0);
    chk("t5_outs_cleared", {Dvld, Kvld, BSY, Trigger, ERR}, 5'b0);
    ticks(15);
    req(1'b1, 1'b0, D1, '0);
    tick();
    chk("t5_idle_en_err", ERR, 1'b1);

    // 6: EN+KDrdy in READY -> re-key wins, EN dropped
    do_reset();
    load_key(K1);
    push(1'b1, KLAT, '0);
    req(1'b1, 1'b1, D1, ONES);
    ticks(12);
    chk("t6_err", ERR, 1'b1);
    chk("t6_dout_unchanged", Dout, '0);
    drain(5);
    push(1'b0, LAT, ONES);
    req(1'b1, 1'b0, '0, '0);
    drain(20);
    ticks(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
